// File: rtl/delay_line_bank_if.sv
// ---------------------------------------------------------------------------
// delay_line_bank_if
//   Bundles the per-channel data/valid/control signals of delay_line_bank.
//   Channel c occupies slice [c*W +: W] of every packed multi-channel field.
//
//   Signals
//     flush      shared synchronous clear of every stage in every channel
//     en         per-channel shift enable
//     dly        per-channel tap select, DLY_W bits per channel
//     in_data    input data, WIDTH bits per channel
//     in_valid   input valid per channel
//     out_data   delayed data, WIDTH bits per channel
//     out_valid  delayed valid per channel
//
//   Modports
//     master  producer / consumer side (drives inputs, reads outputs)
//     slave   delay_line_bank side
// ---------------------------------------------------------------------------
interface delay_line_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 3,
    parameter int DLY_W    = 3
);
    logic                      flush;
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS*DLY_W-1:0] dly;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;

    modport master (
        output flush, en, dly, in_data, in_valid,
        input  out_data, out_valid
    );

    modport slave (
        input  flush, en, dly, in_data, in_valid,
        output out_data, out_valid
    );
endinterface

// File: rtl/delay_line_bank.sv
// ---------------------------------------------------------------------------
// delay_line_bank
//   Bank of CHANNELS independent delay lines, DEPTH stages of {valid, data}
//   each. Every channel shifts only on its own enable and exposes one stage,
//   chosen at run time by its tap field, through a combinational mux.
//   Used to equalise latency between parallel datapaths.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, clears every stage
//     bus    delay_line_bank_if.slave: flush, en, dly, in_data, in_valid,
//            out_data, out_valid
//
//   Parameters
//     CHANNELS      number of delay lines
//     WIDTH         data bits per channel
//     DEPTH         stages per channel (max delay in enabled cycles)
//     DLY_W         tap-select width per channel (may be widened on purpose;
//                   taps >= DEPTH saturate to DEPTH-1)
//     ZERO_INVALID  1: out_data reads 0 whenever out_valid is 0
// ---------------------------------------------------------------------------
module delay_line_bank #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 3,
    parameter int DEPTH        = 8,
    parameter int DLY_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int ZERO_INVALID = 1
) (
    input logic              clk,
    input logic              rst_n,
    delay_line_bank_if.slave bus
);

    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Clamp a requested tap into the physical stage range.
    function automatic logic [TAP_W-1:0] sat_tap(input logic [DLY_W-1:0] sel);
        if (DEPTH == 1) begin
            return '0;
        end
        if (32'(sel) >= 32'(DEPTH - 1)) begin
            return TAP_W'(DEPTH - 1);
        end
        return TAP_W'(sel);
    endfunction

    // Hide stale data behind an invalid stage when ZERO_INVALID is set.
    function automatic logic [WIDTH-1:0] out_gate(input logic v, input logic [WIDTH-1:0] d);
        if ((ZERO_INVALID != 0) && !v) begin
            return '0;
        end
        return d;
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] dat [DEPTH];
        logic             vld [DEPTH];
        logic [TAP_W-1:0] tap;

        // Stage registers: flush outranks the enable, so a sample presented
        // in the flush cycle is dropped rather than captured.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    vld[k] <= 1'b0;
                    dat[k] <= '0;
                end
            end else if (bus.flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    vld[k] <= 1'b0;
                    dat[k] <= '0;
                end
            end else if (bus.en[c]) begin
                vld[0] <= bus.in_valid[c];
                dat[0] <= bus.in_data[c*WIDTH +: WIDTH];
                for (int k = 1; k < DEPTH; k++) begin
                    vld[k] <= vld[k-1];
                    dat[k] <= dat[k-1];
                end
            end
        end

        // Output tap: mux straight off the registers, so a tap change takes
        // effect in the same cycle and inputs never reach outputs directly.
        assign tap                             = sat_tap(bus.dly[c*DLY_W +: DLY_W]);
        assign bus.out_valid[c]                = vld[tap];
        assign bus.out_data[c*WIDTH +: WIDTH]  = out_gate(vld[tap], dat[tap]);
    end

endmodule

// File: tb/tb_delay_line_bank.sv
module tb_delay_line_bank;
    localparam int CH = 4;
    localparam int W  = 3;
    localparam int D  = 8;
    localparam int DW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    delay_line_bank_if #(.CHANNELS(CH), .WIDTH(W), .DLY_W(DW)) bus ();
    delay_line_bank #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .DLY_W(DW), .ZERO_INVALID(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Single-channel instance with a widened tap field to exercise saturation.
    delay_line_bank_if #(.CHANNELS(1), .WIDTH(W), .DLY_W(4)) bus2 ();
    delay_line_bank #(.CHANNELS(1), .WIDTH(W), .DEPTH(D), .DLY_W(4), .ZERO_INVALID(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: per channel, history of accepted samples, newest first.
    logic [W:0] hist [CH][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] od(input int c);
        return bus.out_data[c*W +: W];
    endfunction

    task automatic model_update();
        if (!rst_n || bus.flush) begin
            for (int c = 0; c < CH; c++) hist[c].delete();
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (bus.en[c]) begin
                    hist[c].push_front({bus.in_valid[c], bus.in_data[c*W +: W]});
                    if (hist[c].size() > D) void'(hist[c].pop_back());
                end
            end
        end
    endtask

    function automatic logic [W:0] model_out(input int c);
        int t;
        logic [W:0] e;
        t = int'(bus.dly[c*DW +: DW]);
        if (t > D - 1) t = D - 1;
        e = '0;
        if (t < hist[c].size()) begin
            e = hist[c][t];
            if (!e[W]) e = '0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        // ---------------- Test 1: reset ----------------
        bus.flush    = 1'b0;
        bus.en       = 4'hF;
        bus.dly      = '0;
        bus.in_valid = 4'hF;
        bus.in_data  = 12'hFFF;
        bus2.flush    = 1'b0;
        bus2.en       = 1'b0;
        bus2.dly      = 4'd15;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ov", 32'(bus.out_valid), 32'h0);
        chk("rst_async_od", 32'(bus.out_data), 32'h0);
        tick();
        tick();
        chk("rst_held_ov", 32'(bus.out_valid), 32'h0);
        chk("rst_held_od", 32'(bus.out_data), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ov", 32'(bus.out_valid), 32'h0);
        chk("rst_rel_od", 32'(bus.out_data), 32'h0);
        tick();
        chk("first_en_ov", 32'(bus.out_valid), 32'hF);
        chk("first_en_od", 32'(bus.out_data), 32'hFFF);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = '0;
        bus.in_data  = '0;
        chk("clr_ov", 32'(bus.out_valid), 32'h0);

        // ---------------- Test 2: latency, ch0 tap 3 ----------------
        bus.dly = {3'd0, 3'd0, 3'd0, 3'd3};
        bus.in_valid = 4'b0001;
        bus.in_data[0 +: W] = 3'd5;
        tick();
        chk("lat_e1", 32'(bus.out_valid[0]), 32'h0);
        bus.in_valid = '0;
        bus.in_data  = '0;
        tick();
        chk("lat_e2", 32'(bus.out_valid[0]), 32'h0);
        tick();
        chk("lat_e3", 32'(bus.out_valid[0]), 32'h0);
        tick();
        chk("lat_e4_ov", 32'(bus.out_valid[0]), 32'h1);
        chk("lat_e4_od", 32'(od(0)), 32'd5);
        tick();
        chk("lat_e5_ov", 32'(bus.out_valid[0]), 32'h0);
        chk("lat_e5_od", 32'(od(0)), 32'd0);

        // ---------------- Test 3: enable stall on ch1 ----------------
        bus.dly = {3'd0, 3'd0, 3'd1, 3'd3};
        bus.in_valid = 4'b0010;
        bus.in_data[1*W +: W] = 3'd2;
        tick();
        chk("stall_e1_ov", 32'(bus.out_valid[1]), 32'h0);
        bus.in_data[1*W +: W] = 3'd6;
        tick();
        chk("stall_e2_ov", 32'(bus.out_valid[1]), 32'h1);
        chk("stall_e2_od", 32'(od(1)), 32'd2);
        bus.en = 4'b1101;
        bus.in_valid = 4'b0110;
        bus.in_data[1*W +: W] = 3'd7;
        for (int i = 0; i < 3; i++) begin
            bus.in_data[2*W +: W] = 3'(3 + i);
            tick();
            chk("stall_hold_ov", 32'(bus.out_valid[1]), 32'h1);
            chk("stall_hold_od", 32'(od(1)), 32'd2);
            chk("stall_other_ov", 32'(bus.out_valid[2]), 32'h1);
            chk("stall_other_od", 32'(od(2)), 32'(3 + i));
        end
        bus.en = 4'hF;
        bus.in_valid = '0;
        bus.in_data  = '0;
        tick();
        chk("stall_resume_ov", 32'(bus.out_valid[1]), 32'h1);
        chk("stall_resume_od", 32'(od(1)), 32'd6);
        tick();
        chk("stall_drain_ov", 32'(bus.out_valid[1]), 32'h0);

        // ---------------- Test 4: tap saturation ----------------
        bus.dly = {3'd7, 3'd0, 3'd1, 3'd3};
        bus.in_valid = 4'b1000;
        bus.in_data[3*W +: W] = 3'd3;
        bus2.en = 1'b1;
        bus2.in_valid = 1'b1;
        bus2.in_data = 3'd6;
        tick();
        chk("sat7_e1", 32'(bus.out_valid[3]), 32'h0);
        chk("sat15_e1", 32'(bus2.out_valid), 32'h0);
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("sat7_ov", 32'(bus.out_valid[3]), (k == 8) ? 32'h1 : 32'h0);
            chk("sat7_od", 32'(od(3)), (k == 8) ? 32'd3 : 32'd0);
            chk("sat15_ov", 32'(bus2.out_valid), (k == 8) ? 32'h1 : 32'h0);
            chk("sat15_od", 32'(bus2.out_data), (k == 8) ? 32'd6 : 32'd0);
        end

        // ---------------- Test 5: flush beats enable ----------------
        bus.dly = '0;
        bus.en = 4'hF;
        bus.in_valid = 4'hF;
        bus.in_data = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < D; i++) tick();
        chk("fill_ov", 32'(bus.out_valid), 32'hF);
        chk("fill_od", 32'(bus.out_data), 32'({3'd4, 3'd3, 3'd2, 3'd1}));
        bus.flush = 1'b1;
        bus.in_data = 12'hFFF;
        tick();
        chk("flush_ov", 32'(bus.out_valid), 32'h0);
        chk("flush_od", 32'(bus.out_data), 32'h0);
        bus.flush = 1'b0;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.dly = 12'hFFF;
        for (int i = 0; i < D; i++) begin
            tick();
            chk("flush_gone_ov", 32'(bus.out_valid), 32'h0);
        end

        // ---------------- Test 6a: mixed taps on a ramp ----------------
        bus.dly = {3'd7, 3'd4, 3'd1, 3'd0};
        bus.in_valid = 4'hF;
        for (int n = 0; n < 12; n++) begin
            for (int c = 0; c < CH; c++) bus.in_data[c*W +: W] = 3'(n);
            tick();
            for (int c = 0; c < CH; c++) begin
                int t;
                t = (c == 0) ? 0 : (c == 1) ? 1 : (c == 2) ? 4 : 7;
                chk("ramp_ov", 32'(bus.out_valid[c]), (n >= t) ? 32'h1 : 32'h0);
                chk("ramp_od", 32'(od(c)), (n >= t) ? 32'((n - t) % 8) : 32'h0);
            end
        end

        // ---------------- Test 6b: random en/dly/flush vs model ----------------
        for (int i = 0; i < 200; i++) begin
            bus.flush    = ($urandom_range(0, 15) == 0);
            bus.en       = CH'($urandom());
            bus.in_valid = CH'($urandom());
            bus.in_data  = (CH*W)'($urandom());
            tick();
            bus.dly = (CH*DW)'($urandom());
            #1;
            for (int c = 0; c < CH; c++) begin
                chk("rnd", 32'({bus.out_valid[c], od(c)}), 32'(model_out(c)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
